// File: rtl/controlador_elevador.sv
// Elevator car-motion and door sequencer: latches floor calls, picks the
// travel direction, times floor-to-floor travel and the door-open interval.
//
// Ports:
//   clock         system clock, rising edge
//   reset_n       synchronous active-low reset
//   chamadas      floor-call buttons, bit i requests floor i
//   alerta        overload flag, holds the door open
//   andar_atual   current floor
//   porta_aberta  door open
//   subindo       car moving up
//   descendo      car moving down
//   pedidos       pending-call register
//   ocupado       controller not idle
module controlador_elevador #(
    parameter  int NUM_ANDARES = 4,
    parameter  int TEMPO_ANDAR = 4,
    parameter  int TEMPO_PORTA = 8,
    localparam int W = (NUM_ANDARES > 1) ? $clog2(NUM_ANDARES) : 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_ANDARES-1:0] chamadas,
    input  logic                   alerta,
    output logic [W-1:0]           andar_atual,
    output logic                   porta_aberta,
    output logic                   subindo,
    output logic                   descendo,
    output logic [NUM_ANDARES-1:0] pedidos,
    output logic                   ocupado
);

    localparam int CA = $clog2(TEMPO_ANDAR + 1);
    localparam int CP = $clog2(TEMPO_PORTA + 1);
    localparam logic [CA-1:0] CARGA_ANDAR = CA'(TEMPO_ANDAR - 1);
    localparam logic [CP-1:0] CARGA_PORTA = CP'(TEMPO_PORTA - 1);
    localparam logic [W-1:0]  ANDAR_MAX   = W'(NUM_ANDARES - 1);
    localparam logic [NUM_ANDARES-1:0] UM =
        {{(NUM_ANDARES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        PARADO,
        SUBINDO,
        DESCENDO,
        PORTA_ABERTA
    } estado_t;

    estado_t          estado;
    estado_t          decisao;
    logic [CA-1:0]    cont_andar;
    logic [CP-1:0]    cont_porta;
    logic             dir_sobe;

    logic [W-1:0]           vizinho;
    logic [NUM_ANDARES-1:0] hot_atual;
    logic [NUM_ANDARES-1:0] hot_vizinho;
    logic aqui, acima, abaixo;
    logic acima_viz, abaixo_viz;
    logic segue, fecha, usa_d;

    function automatic logic tem_acima(
        input logic [NUM_ANDARES-1:0] p,
        input logic [W-1:0]           f
    );
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_ANDARES; i++)
            if (i > int'(f)) r = r | p[i];
        return r;
    endfunction

    function automatic logic tem_abaixo(
        input logic [NUM_ANDARES-1:0] p,
        input logic [W-1:0]           f
    );
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_ANDARES; i++)
            if (i < int'(f)) r = r | p[i];
        return r;
    endfunction

    always_comb begin
        aqui   = pedidos[andar_atual];
        acima  = tem_acima(pedidos, andar_atual);
        abaixo = tem_abaixo(pedidos, andar_atual);

        // Floor reached at the end of the current leg, saturated at the ends.
        vizinho = andar_atual;
        if (estado == DESCENDO) begin
            if (andar_atual != '0) vizinho = andar_atual - W'(1);
        end else begin
            if (andar_atual != ANDAR_MAX) vizinho = andar_atual + W'(1);
        end

        hot_atual   = UM << andar_atual;
        hot_vizinho = UM << vizinho;
        acima_viz   = tem_acima(pedidos, vizinho);
        abaixo_viz  = tem_abaixo(pedidos, vizinho);
        segue = (estado == SUBINDO) ? acima_viz : abaixo_viz;

        // A call at this floor reloads the timer just like overload does.
        fecha = (estado == PORTA_ABERTA) && !alerta &&
                !chamadas[andar_atual] && (cont_porta == '0);
        usa_d = (estado == PARADO) || fecha;

        // The current floor is always clear while the door is open, so
        // aqui is 0 whenever this is used on door close.
        if (aqui)
            decisao = PORTA_ABERTA;
        else if (acima && (dir_sobe || !abaixo))
            decisao = SUBINDO;
        else if (abaixo)
            decisao = DESCENDO;
        else
            decisao = PARADO;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado      <= PARADO;
            andar_atual <= '0;
            pedidos     <= '0;
            dir_sobe    <= 1'b1;
            cont_andar  <= '0;
            cont_porta  <= '0;
        end else begin
            pedidos <= pedidos | chamadas;
            if (usa_d) begin
                estado <= decisao;
                unique case (decisao)
                    PORTA_ABERTA: begin
                        cont_porta <= CARGA_PORTA;
                        pedidos    <= (pedidos | chamadas) & ~hot_atual;
                    end
                    SUBINDO: begin
                        dir_sobe   <= 1'b1;
                        cont_andar <= CARGA_ANDAR;
                    end
                    DESCENDO: begin
                        dir_sobe   <= 1'b0;
                        cont_andar <= CARGA_ANDAR;
                    end
                    default: ;
                endcase
            end else begin
                unique case (estado)
                    SUBINDO, DESCENDO: begin
                        if (cont_andar != '0) begin
                            cont_andar <= cont_andar - 1'b1;
                        end else begin
                            andar_atual <= vizinho;
                            if (pedidos[vizinho]) begin
                                estado     <= PORTA_ABERTA;
                                cont_porta <= CARGA_PORTA;
                                pedidos    <= (pedidos | chamadas)
                                              & ~hot_vizinho;
                            end else if (segue) begin
                                cont_andar <= CARGA_ANDAR;
                            end else begin
                                estado <= PARADO;
                            end
                        end
                    end
                    PORTA_ABERTA: begin
                        pedidos <= (pedidos | chamadas) & ~hot_atual;
                        if (alerta || chamadas[andar_atual])
                            cont_porta <= CARGA_PORTA;
                        else
                            cont_porta <= cont_porta - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign porta_aberta = (estado == PORTA_ABERTA);
    assign subindo      = (estado == SUBINDO);
    assign descendo     = (estado == DESCENDO);
    assign ocupado      = (estado != PARADO);

    // The decision rules never send the car past either end.
    a_teto: assert property (@(posedge clock) disable iff (!reset_n)
        (estado == SUBINDO && cont_andar == '0) |-> andar_atual != ANDAR_MAX);
    a_piso: assert property (@(posedge clock) disable iff (!reset_n)
        (estado == DESCENDO && cont_andar == '0) |-> andar_atual != '0);

endmodule

// File: tb/tb_controlador_elevador.sv
// Bench for controlador_elevador: directed scenarios with literal
// expectations plus randomized traffic against an in-bench elevator model.
module tb_controlador_elevador;

    localparam int NA = 4;
    localparam int TA = 4;
    localparam int TP = 8;
    localparam int W  = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NA-1:0] chamadas;
    logic          alerta;
    logic [W-1:0]  andar_atual;
    logic          porta_aberta, subindo, descendo, ocupado;
    logic [NA-1:0] pedidos;

    int errors = 0;
    int checks = 0;
    int n = 0;

    controlador_elevador #(
        .NUM_ANDARES(NA),
        .TEMPO_ANDAR(TA),
        .TEMPO_PORTA(TP)
    ) dut (
        .clock(clk),
        .reset_n(reset_n),
        .chamadas(chamadas),
        .alerta(alerta),
        .andar_atual(andar_atual),
        .porta_aberta(porta_aberta),
        .subindo(subindo),
        .descendo(descendo),
        .pedidos(pedidos),
        .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    // Elevator model: floor, motion sign (-1/0/+1), door flag and
    // elapsed-cycle ages for the current leg and the door.
    int            m_floor = 0;
    int            m_mov = 0;
    bit            m_door = 0;
    bit            m_up = 1;
    int            m_leg = 0;
    int            m_dage = 0;
    logic [NA-1:0] m_pend = '0;
    bit            m_ok = 0;

    function automatic bit above(input logic [NA-1:0] p, input int f);
        for (int i = f + 1; i < NA; i++) if (p[i]) return 1;
        return 0;
    endfunction

    function automatic bit below(input logic [NA-1:0] p, input int f);
        for (int i = 0; i < f; i++) if (p[i]) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin : modelo
        int nf, nmov, nleg, ndage;
        bit nport, nup, decide, ha, hb;
        logic [NA-1:0] base, np;
        if (!reset_n) begin
            m_floor <= 0; m_mov <= 0; m_door <= 0; m_up <= 1;
            m_leg <= 0; m_dage <= 0; m_pend <= '0; m_ok <= 1;
        end else begin
            nf = m_floor; nmov = m_mov; nport = m_door; nup = m_up;
            nleg = m_leg; ndage = m_dage; decide = 0; base = m_pend;
            if (m_door) begin
                if (alerta || chamadas[m_floor]) ndage = 0;
                else if (m_dage == TP - 1) begin
                    nport = 0; decide = 1; base[m_floor] = 1'b0;
                end else ndage = m_dage + 1;
            end else if (m_mov != 0) begin
                if (m_leg == TA - 1) begin
                    nf = m_floor + m_mov; nleg = 0;
                    if (m_pend[nf]) begin
                        nmov = 0; nport = 1; ndage = 0;
                    end else if (!((m_mov > 0) ? above(m_pend, nf)
                                                : below(m_pend, nf)))
                        nmov = 0;
                end else nleg = m_leg + 1;
            end else decide = 1;
            if (decide) begin
                ha = above(base, nf);
                hb = below(base, nf);
                if (base[nf]) begin
                    nport = 1; ndage = 0;
                end else if (ha && (m_up || !hb)) begin
                    nmov = 1; nup = 1; nleg = 0;
                end else if (hb) begin
                    nmov = -1; nup = 0; nleg = 0;
                end
            end
            np = m_pend | chamadas;
            if (nport) np[nf] = 1'b0;
            m_floor <= nf; m_mov <= nmov; m_door <= nport; m_up <= nup;
            m_leg <= nleg; m_dage <= ndage; m_pend <= np;
        end
    end

    always @(negedge clk) begin : compara
        logic [15:0] got, exp;
        if (m_ok) begin
            got = 16'({andar_atual, porta_aberta, subindo, descendo,
                       ocupado, pedidos});
            exp = 16'({W'(m_floor), m_door, m_mov == 1, m_mov == -1,
                       (m_door || m_mov != 0), m_pend});
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL modelo t=%0t dut=%h exp=%h", $time, got, exp);
            end
            checks++;
            if (int'(porta_aberta) + int'(subindo) + int'(descendo) > 1) begin
                errors++;
                $display("FAIL exclusivo t=%0t porta=%b sobe=%b desce=%b",
                         $time, porta_aberta, subindo, descendo);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic adv(input int k);
        while (n < k) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        chamadas = '0;
        alerta = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
    endtask

    initial begin
        int abertos;
        reset_n = 1'b0;
        chamadas = '0;
        alerta = 1'b0;

        // 1: call to floor 2 from idle at floor 0
        do_reset();
        chk("reset saidas", int'({andar_atual, porta_aberta, subindo,
                                  descendo, ocupado, pedidos}), 0);
        chamadas = 4'b0100;
        adv(1); chamadas = '0;
        chk("t1 pedidos", int'(pedidos), 4);
        chk("t1 parado", int'(subindo), 0);
        adv(2);
        chk("t1 sobe", int'(subindo), 1);
        adv(5);
        chk("t1 andar0", int'(andar_atual), 0);
        adv(6);
        chk("t1 andar1", int'(andar_atual), 1);
        adv(9);
        chk("t1 ainda1", int'(andar_atual), 1);
        abertos = 0;
        for (int k = 10; k < 18; k++) begin
            adv(k);
            abertos += int'(porta_aberta);
            if (k == 10) begin
                chk("t1 andar2", int'(andar_atual), 2);
                chk("t1 limpo", int'(pedidos), 0);
                chk("t1 parou", int'(subindo), 0);
            end
        end
        chk("t1 ciclos porta", abertos, 8);
        adv(18);
        chk("t1 fecha", int'(porta_aberta), 0);
        chk("t1 ocioso", int'(ocupado), 0);

        // 2: call at the current floor
        do_reset();
        chamadas = 4'b0001;
        adv(1); chamadas = '0;
        adv(2);
        chk("t2 porta", int'(porta_aberta), 1);
        chk("t2 andar", int'(andar_atual), 0);
        adv(9);
        chk("t2 porta fim", int'(porta_aberta), 1);
        adv(10);
        chk("t2 fecha", int'(porta_aberta), 0);

        // 3: overload holds the door
        do_reset();
        chamadas = 4'b0001;
        adv(1); chamadas = '0;
        adv(3); alerta = 1'b1;
        for (int k = 4; k < 23; k++) begin
            adv(k);
            chk("t3 segura", int'(porta_aberta), 1);
        end
        adv(23); alerta = 1'b0;
        adv(30);
        chk("t3 ultimo", int'(porta_aberta), 1);
        adv(31);
        chk("t3 fecha", int'(porta_aberta), 0);

        // 4: up to floor 3 first, then down to floor 0
        do_reset();
        chamadas = 4'b1000;
        adv(1); chamadas = '0;
        adv(3); chamadas = 4'b0001;
        adv(4); chamadas = '0;
        adv(6);
        chk("t4 andar1", int'(andar_atual), 1);
        chk("t4 pend", int'(pedidos), 9);
        adv(14);
        chk("t4 topo", int'(andar_atual), 3);
        chk("t4 porta", int'(porta_aberta), 1);
        chk("t4 resta", int'(pedidos), 1);
        adv(22);
        chk("t4 desce", int'(descendo), 1);
        adv(26);
        chk("t4 andar2", int'(andar_atual), 2);
        adv(34);
        chk("t4 terreo", int'(andar_atual), 0);
        chk("t4 porta0", int'(porta_aberta), 1);
        chk("t4 vazio", int'(pedidos), 0);

        // 5: call at the open floor reloads the door timer
        do_reset();
        chamadas = 4'b0100;
        adv(1); chamadas = '0;
        adv(15); chamadas = 4'b0100;
        adv(16); chamadas = '0;
        chk("t5 nao trava", int'(pedidos), 0);
        adv(18);
        chk("t5 recarga", int'(porta_aberta), 1);
        adv(23);
        chk("t5 ultimo", int'(porta_aberta), 1);
        adv(24);
        chk("t5 fecha", int'(porta_aberta), 0);

        // 6: reset mid-travel
        do_reset();
        chamadas = 4'b0100;
        adv(1); chamadas = '0;
        adv(7);
        chk("t6 viajando", int'(subindo), 1);
        reset_n = 1'b0;
        adv(8);
        chk("t6 reset", int'({andar_atual, porta_aberta, subindo,
                              descendo, ocupado, pedidos}), 0);
        reset_n = 1'b1;

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset_n = ($urandom_range(0, 799) != 0);
            if ($urandom_range(0, 7) == 0)
                chamadas = NA'($urandom_range(1, (1 << NA) - 1));
            else
                chamadas = '0;
            if ($urandom_range(0, 19) == 0) alerta = ~alerta;
        end
        alerta = 1'b0;
        chamadas = '0;
        repeat (60) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
